// File: rtl/i2c_btn_write_seq.sv
// Button-driven I2C register writer: edits an 8-bit value and sends it as START/addr/reg/data/STOP.
// Optional `I2C_SEQ_RETRY_EN: a NACKed transaction is replayed once before reporting failure.
module i2c_btn_write_seq #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter logic [7:0] REG_ADDR   = 8'h00,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_send,
    output logic       o_cmd_valid,
    output logic [1:0] o_cmd,
    output logic [7:0] o_tx_data,
    input  logic       i_cmd_ready,
    input  logic       i_cmd_done,
    input  logic       i_ack_err,
    output logic [7:0] o_value,
    output logic       o_busy,
    output logic       o_nack,
    output logic       o_tx_done
);

    // state    | meaning
    // ST_IDLE  | no transaction; buttons edit the value
    // ST_START | START condition issued / awaiting done
    // ST_ADDR  | {SLAVE_ADDR,W} byte issued / awaiting done
    // ST_REG   | REG_ADDR byte issued / awaiting done
    // ST_DATA  | latched value byte issued / awaiting done
    // ST_STOP  | STOP condition issued / awaiting done
    // In non-idle states o_cmd_valid=1 is the issue phase, o_cmd_valid=0 the wait phase.
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_ADDR, ST_REG, ST_DATA, ST_STOP
    } state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_STOP  = 2'd2;

    state_t     state_q, state_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] value_q, value_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;
    logic       nack_seen_q, nack_seen_d;
    logic       tx_done_q, tx_done_d;
    logic       launch;
    state_t     launch_st;
`ifdef I2C_SEQ_RETRY_EN
    logic       retry_used_q, retry_used_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        tx_data_d   = tx_data_q;
        value_d     = value_q;
        data_d      = data_q;
        busy_d      = busy_q;
        nack_d      = nack_q;
        nack_seen_d = nack_seen_q;
        tx_done_d   = 1'b0;
        launch      = 1'b0;
        launch_st   = ST_IDLE;
`ifdef I2C_SEQ_RETRY_EN
        retry_used_d = retry_used_q;
`endif
        if (state_q == ST_IDLE) begin
            if (i_btn_send) begin
                launch      = 1'b1;
                launch_st   = ST_START;
                busy_d      = 1'b1;
                data_d      = value_q;
                nack_seen_d = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
                retry_used_d = 1'b0;
`endif
            end else if (i_btn_up && !i_btn_down) begin
                value_d = value_q + 8'd1;
            end else if (i_btn_down && !i_btn_up) begin
                value_d = value_q - 8'd1;
            end
        end else if (cmd_valid_q) begin
            if (i_cmd_ready) cmd_valid_d = 1'b0;
        end else if (i_cmd_done) begin
            // A NACK on any data byte skips straight to STOP.
            if (i_ack_err && (state_q inside {ST_ADDR, ST_REG, ST_DATA})) begin
                nack_seen_d = 1'b1;
                launch      = 1'b1;
                launch_st   = ST_STOP;
            end else begin
                case (state_q)
                    ST_START: begin launch = 1'b1; launch_st = ST_ADDR; end
                    ST_ADDR:  begin launch = 1'b1; launch_st = ST_REG;  end
                    ST_REG:   begin launch = 1'b1; launch_st = ST_DATA; end
                    ST_DATA:  begin launch = 1'b1; launch_st = ST_STOP; end
                    default: begin
`ifdef I2C_SEQ_RETRY_EN
                        if (nack_seen_q && !retry_used_q) begin
                            launch       = 1'b1;
                            launch_st    = ST_START;
                            retry_used_d = 1'b1;
                            nack_seen_d  = 1'b0;
                        end else
`endif
                        begin
                            state_d   = ST_IDLE;
                            busy_d    = 1'b0;
                            tx_done_d = 1'b1;
                            nack_d    = nack_seen_q;
                            cmd_d     = CMD_START;
                            tx_data_d = 8'h00;
                        end
                    end
                endcase
            end
        end

        if (launch) begin
            state_d     = launch_st;
            cmd_valid_d = 1'b1;
            case (launch_st)
                ST_START: begin cmd_d = CMD_START; tx_data_d = 8'h00;             end
                ST_ADDR:  begin cmd_d = CMD_WRITE; tx_data_d = {SLAVE_ADDR, 1'b0}; end
                ST_REG:   begin cmd_d = CMD_WRITE; tx_data_d = REG_ADDR;          end
                ST_DATA:  begin cmd_d = CMD_WRITE; tx_data_d = data_q;            end
                default:  begin cmd_d = CMD_STOP;  tx_data_d = 8'h00;             end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_START;
            tx_data_q   <= 8'h00;
            value_q     <= INIT_VALUE;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            nack_q      <= 1'b0;
            nack_seen_q <= 1'b0;
            tx_done_q   <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_used_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            tx_data_q   <= tx_data_d;
            value_q     <= value_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            nack_q      <= nack_d;
            nack_seen_q <= nack_seen_d;
            tx_done_q   <= tx_done_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_used_q <= retry_used_d;
`endif
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_tx_data   = tx_data_q;
    assign o_value     = value_q;
    assign o_busy      = busy_q;
    assign o_nack      = nack_q;
    assign o_tx_done   = tx_done_q;

endmodule
